// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: 4-deep byte FIFO, status/control register, interrupt on frame end.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module bus_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hE0,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       TX
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    STAT_ADDR = BASE_ADDR + 8'd1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    fifo_mem [4];
    logic [1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q, count_d;
    logic          ie_q, ovf_q, irq_q;
    logic          rd_en_q;
    logic [7:0]    rd_data_q;

    logic       pop, push_req, push_ok, irq_evt, bit_tick, stat_wr, rd_req;
    logic       fifo_empty, fifo_full, busy;
    logic [7:0] status;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign busy       = (state_q != IDLE);
    assign status     = {3'b000, ie_q, ovf_q, fifo_empty, fifo_full, busy};
    assign bit_tick   = (baud_q == BAUD_MAX);
    assign push_req   = BUS_WE && (BUS_ADDR == BASE_ADDR);
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign stat_wr    = BUS_WE && (BUS_ADDR == STAT_ADDR);
    assign rd_req     = !BUS_WE && ((BUS_ADDR == BASE_ADDR) || (BUS_ADDR == STAT_ADDR));

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_tick ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;
        irq_evt   = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_tick) state_d = DATA;
            end
            DATA: begin
                tx_d = shift_q[bit_idx_q];
                if (bit_tick) begin
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = ^shift_q;
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        irq_evt = ie_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= BUS_DATA;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ie_q      <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            count_q   <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            if (stat_wr) ie_q <= BUS_DATA[0];
            if (push_req && !push_ok)      ovf_q <= 1'b1;
            else if (stat_wr && BUS_DATA[3]) ovf_q <= 1'b0;
            // A new frame-complete event outranks a simultaneous acknowledge.
            if (irq_evt)                irq_q <= 1'b1;
            else if (BUS_INTERRUPT_ACK) irq_q <= 1'b0;
            rd_en_q <= rd_req;
            if (rd_req) rd_data_q <= (BUS_ADDR == STAT_ADDR) ? status : {5'b00000, count_q};
        end
    end

    assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;
    assign TX                  = tx_q;
    assign BUS_INTERRUPT_RAISE = irq_q;
endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: register-access table, hand-written corner sequences, and random writes
// checked cycle by cycle against a frame-timeline model of the serial line.
module tb_bus_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;
    localparam int K_WR = 0, K_RD = 1, K_PB = 2;

    logic       clk = 1'b0, rst_n = 1'b0, we = 1'b0, ack = 1'b0, drv_en = 1'b0;
    logic [7:0] addr = 8'h00, drv_d = 8'h00;
    wire  [7:0] bus_data;
    logic       tx, irq;

    assign bus_data = drv_en ? drv_d : 8'hzz;
    always #5 clk = ~clk;

    bus_uart_tx #(.BASE_ADDR(8'hE0), .CLKS_PER_BIT(CPB)) dut (
        .CLK(clk), .RESET(rst_n), .BUS_DATA(bus_data), .BUS_ADDR(addr), .BUS_WE(we),
        .BUS_INTERRUPT_RAISE(irq), .BUS_INTERRUPT_ACK(ack), .TX(tx)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_vec = 0, n_bad = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %02h expected %02h", nm, edge_n, act, exp);
        end
    endtask

    // Reference model: each accepted byte starts at max(push edge + 1, previous start + FRAME).
    typedef struct { int t; logic [7:0] d; } ev_t;
    ev_t  wq[$], pend[$], frames[$];
    int   last_pop = -100000;
    logic ovf_m = 1'b0;

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int n);
        logic r = 1'b1;
        for (int i = frames.size() - 1; i >= 0 && i >= frames.size() - 2; i--) begin
            int j = n - frames[i].t - 1;
            if (j >= 0 && j < FRAME) r = frame_bit(frames[i].d, j / CPB);
        end
        return r;
    endfunction

    task automatic model_step(input int n);
        logic pop_now;
        int   occ;
        while (wq.size() > 0 && wq[0].t < n) void'(wq.pop_front());
        pop_now = (pend.size() > 0) && (n > pend[0].t) && (n >= last_pop + FRAME);
        occ = pend.size();
        if (wq.size() > 0 && wq[0].t == n) begin
            if (occ < 4 || pop_now) pend.push_back(wq[0]);
            else ovf_m = 1'b1;
            void'(wq.pop_front());
        end
        if (pop_now) begin
            frames.push_back('{n, pend[0].d});
            void'(pend.pop_front());
            last_pop = n;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            model_step(edge_n);
            check("tx_line", {7'b0, tx}, {7'b0, exp_tx(edge_n)});
        end
    end

    task automatic rst_assert();
        #2;
        rst_n = 1'b0;
        wq.delete(); pend.delete(); frames.delete();
        last_pop = -100000;
        ovf_m = 1'b0;
    endtask

    task automatic rst_release();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; we = 1'b1; drv_d = d; drv_en = 1'b1;
        if (a == 8'hE0) wq.push_back('{edge_n + 1, d});
        @(negedge clk);
        we = 1'b0; drv_en = 1'b0; addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string nm);
        addr = a; we = 1'b0;
        @(negedge clk);
        addr = 8'h00;
        check(nm, bus_data, exp);
    endtask

    // The bench drives zero onto the bus; any DUT driver on it would disturb the value read back.
    task automatic bus_probe(input logic [7:0] a, input string nm);
        addr = a; we = 1'b0;
        @(negedge clk);
        addr = 8'h00; drv_d = 8'h00; drv_en = 1'b1;
        #1;
        check(nm, bus_data, 8'h00);
        drv_en = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    typedef struct { int kind; logic [7:0] a; logic [7:0] d; string nm; } vec_t;
    vec_t tbl[13];

    initial begin
        int e;
        int gap;

        tbl[0]  = '{K_RD, 8'hE1, 8'h04, "stat_reset"};
        tbl[1]  = '{K_RD, 8'hE0, 8'h00, "count_reset"};
        tbl[2]  = '{K_PB, 8'h55, 8'h00, "hiz_other"};
        tbl[3]  = '{K_WR, 8'hE1, 8'h01, "ie_set"};
        tbl[4]  = '{K_RD, 8'hE1, 8'h14, "stat_ie"};
        tbl[5]  = '{K_WR, 8'hE1, 8'h00, "ie_clr"};
        tbl[6]  = '{K_RD, 8'hE1, 8'h04, "stat_ie_clr"};
        tbl[7]  = '{K_PB, 8'hE2, 8'h00, "hiz_e2"};
        tbl[8]  = '{K_WR, 8'hE0, 8'h11, "push_11"};
        tbl[9]  = '{K_WR, 8'hE0, 8'h22, "push_22"};
        tbl[10] = '{K_WR, 8'hE0, 8'h33, "push_33"};
        tbl[11] = '{K_RD, 8'hE0, 8'h02, "count_2"};
        tbl[12] = '{K_RD, 8'hE1, 8'h01, "stat_busy"};

        rst_assert(); rst_release();
        for (int i = 0; i < 13; i++) begin
            case (tbl[i].kind)
                K_WR:    bus_write(tbl[i].a, tbl[i].d);
                K_RD:    bus_read(tbl[i].a, tbl[i].d, tbl[i].nm);
                default: bus_probe(tbl[i].a, tbl[i].nm);
            endcase
        end

        // Single frame of A5: start bit appears two edges after the write.
        rst_assert(); rst_release();
        bus_write(8'hE0, 8'hA5);
        check("a5_idle_e0", {7'b0, tx}, 8'h01);
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            check("a5_frame", {7'b0, tx}, {7'b0, (k < 2) ? 1'b1 : frame_bit(8'hA5, (k - 2) / CPB)});
        end
        bus_read(8'hE1, 8'h04, "a5_not_busy");
        check("a5_no_irq", {7'b0, irq}, 8'h00);

        // Overflow: one byte in flight, five more written back to back.
        rst_assert(); rst_release();
        bus_write(8'hE0, 8'h3C);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) bus_write(8'hE0, 8'(i));
        bus_read(8'hE1, 8'h0B, "ovf_stat");
        bus_read(8'hE0, 8'h04, "ovf_count");
        bus_write(8'hE1, 8'h08);
        bus_read(8'hE1, 8'h03, "ovf_clr");
        repeat (5 * FRAME + 8) @(negedge clk);
        bus_read(8'hE1, 8'h04, "ovf_drained");

        // Interrupt raise, acknowledge, and raise winning over a simultaneous acknowledge.
        rst_assert(); rst_release();
        bus_write(8'hE1, 8'h01);
        bus_write(8'hE0, 8'h5A);
        e = edge_n;
        wait_until(e + FRAME);
        check("irq_before", {7'b0, irq}, 8'h00);
        @(negedge clk);
        check("irq_set", {7'b0, irq}, 8'h01);
        repeat (3) @(negedge clk);
        check("irq_hold", {7'b0, irq}, 8'h01);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("irq_ack", {7'b0, irq}, 8'h00);
        bus_write(8'hE0, 8'hC3);
        e = edge_n;
        wait_until(e + FRAME);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("irq_raise_wins", {7'b0, irq}, 8'h01);
        @(negedge clk);
        check("irq_after_win", {7'b0, irq}, 8'h01);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("irq_ack2", {7'b0, irq}, 8'h00);

        // Reset in the middle of the data bits.
        rst_assert(); rst_release();
        bus_write(8'hE0, 8'h00);
        e = edge_n;
        wait_until(e + 10);
        check("tx_mid_data", {7'b0, tx}, 8'h00);
        rst_assert();
        #1;
        check("tx_rst_async", {7'b0, tx}, 8'h01);
        check("irq_rst", {7'b0, irq}, 8'h00);
        rst_release();
        bus_read(8'hE1, 8'h04, "stat_after_rst");
        bus_read(8'hE0, 8'h00, "count_after_rst");

        // Random writes with random gaps; the line monitor checks every cycle against the model.
        rst_assert(); rst_release();
        for (int i = 0; i < 60; i++) begin
            gap = $urandom_range(0, 24);
            repeat (gap) @(negedge clk);
            bus_write(8'hE0, 8'($urandom));
        end
        repeat (5 * FRAME + 8) @(negedge clk);
        bus_read(8'hE1, {3'b000, 1'b0, ovf_m, 1'b1, 1'b0, 1'b0}, "rand_status");
        bus_read(8'hE0, 8'h00, "rand_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hE0, the bus address of the data register; the status/control register is at BASE_ADDR+1.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, the number of CLK cycles per serial bit (115200 baud at 100 MHz).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port BUS_DATA, inout, 8 bits: the shared processor data bus.
REQ-006 SHALL have port BUS_ADDR, input, 8 bits: the shared processor address bus.
REQ-007 SHALL have port BUS_WE, input, 1 bit: bus write strobe (1 = write, 0 = read).
REQ-008 SHALL have port BUS_INTERRUPT_RAISE, output, 1 bit: interrupt request to the processor.
REQ-009 SHALL have port BUS_INTERRUPT_ACK, input, 1 bit: interrupt acknowledge from the processor.
REQ-010 SHALL have port TX, output, 1 bit: serial line; idle state is high.

Function
REQ-011 Write to BASE_ADDR (BUS_WE=1) SHALL push BUS_DATA into a 4-entry FIFO; if the FIFO is full and no pop occurs in the same cycle, the byte is dropped and the sticky OVF flag is set.
REQ-012 A write to a full FIFO in the same cycle as a pop SHALL be accepted.
REQ-013 Write to BASE_ADDR+1 SHALL set IE from bit0, and writing 1 to bit3 SHALL clear OVF; all other bits are ignored.
REQ-014 Reads (BUS_WE=0) of either address SHALL drive BUS_DATA from a register one cycle after the address is sampled; BUS_DATA SHALL be high-Z at all other times.
REQ-015 Read data at BASE_ADDR+1 SHALL be {3'b0, IE, OVF, EMPTY, FULL, BUSY}; read data at BASE_ADDR SHALL be the FIFO occupancy count (0-4).
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY exists only under REQ-027.
REQ-017 IDLE: TX=1; when the FIFO is non-empty, pop the head into the shift register and go to START.
REQ-018 START: TX=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7 go to PARITY or STOP.
REQ-020 STOP: TX=1 for CLKS_PER_BIT cycles; then pop the next byte and go straight to START if the FIFO is non-empty, otherwise go to IDLE (back-to-back frames have no idle gap).
REQ-021 Latency: a write sampled at edge E into an empty FIFO with the FSM in IDLE SHALL drive TX low from edge E+2 (push at E, pop at E+1, START at E+2).
REQ-022 BUSY SHALL be 1 in every state except IDLE; EMPTY and FULL reflect the FIFO occupancy.
REQ-023 The baud counter SHALL count 0 to CLKS_PER_BIT-1 and wrap; FIFO pointers SHALL be 2 bits and wrap modulo 4.
REQ-024 On the STOP-to-IDLE transition with IE=1, BUS_INTERRUPT_RAISE SHALL go to 1 and stay there until a cycle with BUS_INTERRUPT_ACK=1, after which it is 0 on the next edge.
REQ-025 If raise and ack occur in the same cycle, raise SHALL win.

Reset
REQ-026 While RESET=0, the block SHALL force, asynchronously: TX=1, FSM=IDLE, FIFO empty (pointers and count 0), IE=0, OVF=0, BUS_INTERRUPT_RAISE=0, BUS_DATA high-Z, counters 0; a frame in progress is abandoned with no partial stop bit.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL send one even-parity bit (XOR of the 8 data bits) between DATA and STOP; without it, DATA goes directly to STOP and frames are 10 bits.

Verification (CLKS_PER_BIT=4, BASE_ADDR=8'hE0)
REQ-028 Reset release, write 8'hA5 to E0 -> TX low from edge E+2, then bits 1,0,1,0,0,1,0,1 each held 4 cycles, then stop high; BUSY=0 afterwards.
REQ-029 Write 5 bytes to E0 back-to-back while the first is still in flight -> 4 accepted, status OVF=1; writing 8'h08 to E1 clears OVF; frames are contiguous with no idle gap.
REQ-030 Write 8'h01 to E1, then send one byte -> RAISE=1 after the stop bit; pulse ACK -> RAISE=0 on the next edge; ACK and a new raise in the same cycle -> RAISE stays 1.
REQ-031 Read E1 with FIFO empty and IDLE -> BUS_DATA=8'h04 one cycle later; BUS_DATA is high-Z when BUS_ADDR is not E0/E1.
REQ-032 Assert RESET=0 mid-DATA -> TX=1 immediately, status 8'h04 after release.
REQ-033 With UART_TX_PARITY_EN defined, send 8'h07 -> parity bit 1 before stop; 11-bit frame.
